display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 33 +++
 rtl/display_timer.sv | 51 +++++
 rtl/display_scan.sv | 167 ++++++++++++++++
 tb/tb_display_scan.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed 4-digit display scanner:
//   - scan FSM state encoding
//   - digit count and index width
//   - cycle counter width
//   - segment bit positions inside an 8-bit digit pattern (a..g, dp)
// No ports; imported by display_timer and display_scan.
// ----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;
    localparam int CNT_W      = 16;

    // Segment bit positions: bits 6:0 are g..a, bit 7 is the decimal point.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    localparam int SEG_W  = SEG_DP + 1;

endpackage

// File: rtl/display_timer.sv
// ----------------------------------------------------------------------------
// display_timer
// Loadable down-counter that times the BLANK and ON phases of the scanner.
// Loading a duration L makes tc assert on the L-th cycle after the load edge,
// so a phase entered on a load edge lasts exactly L clocks. The counter
// parks at zero when not reloaded.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   clear     in   synchronous clear to zero (highest priority)
//   load      in   load a new duration
//   load_val  in   duration in clocks (1..65535)
//   tc        out  terminal count: current cycle is the last of the phase
// ----------------------------------------------------------------------------
module display_timer
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            // Count holds L-1 .. 0, giving L cycles per load.
            count_d = (load_val == '0) ? '0 : load_val - CNT_W'(1);
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/display_scan.sv
// ----------------------------------------------------------------------------
// display_scan
// Time-multiplexed scanner for a 4-digit 7-segment display. Each digit gets
// BLANK_CYCLES all-off clocks (anti-ghosting) followed by DIGIT_CYCLES clocks
// of drive. Digit patterns are captured into shadow registers at scan start
// and at every frame end, so register writes never tear a frame.
// Ports:
//   clk                   in   system clock, rising edge
//   reset                 in   asynchronous active-low reset
//   enable                in   scanning runs while high
//   segment0..segment3    in   digit patterns, bit7 = dp, bits6:0 = g..a, 1 = lit
//   anode[3:0]            out  digit select, anode[i] drives digit i
//   cathode[7:0]          out  segment drive, same bit order as segmentN
//   frame_done            out  one-clock pulse at the end of digit 3 drive
// All outputs are registered; they reflect the FSM state one clock later,
// except that a low enable turns them off on the very edge it is sampled.
// ----------------------------------------------------------------------------
module display_scan
    import display_pkg::*;
#(
    parameter logic [15:0] DIGIT_CYCLES     = 16'd50000,
    parameter logic [7:0]  BLANK_CYCLES     = 8'd100,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SEG_W-1:0]      segment0,
    input  logic [SEG_W-1:0]      segment1,
    input  logic [SEG_W-1:0]      segment2,
    input  logic [SEG_W-1:0]      segment3,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEG_W-1:0]      cathode,
    output logic                  frame_done
);

    // XOR masks: the "off" pattern doubles as the polarity inversion mask.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYCLES);
    localparam bit                    HAS_BLANK  = (BLANK_CYCLES != 8'd0);

    state_e                               state_q, state_d;
    logic [DIGIT_W-1:0]                   digit_q, digit_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]     shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]     seg_in;
    logic [NUM_DIGITS-1:0]                anode_q, anode_d;
    logic [SEG_W-1:0]                     cathode_q, cathode_d;
    logic                                 frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]                lit_anode;
    logic [SEG_W-1:0]                     lit_seg;
    logic                                 start_digit;
    logic                                 tmr_clear;
    logic                                 tmr_load;
    logic [CNT_W-1:0]                     tmr_val;
    logic                                 tmr_tc;

    assign seg_in = {segment3, segment2, segment1, segment0};

    display_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        start_digit  = 1'b0;
        tmr_clear    = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = DIGIT_CYCLES;

        // Drive pattern in true (active-high) sense; polarity applied below.
        lit_anode = '0;
        lit_seg   = '0;
        if (state_q == ST_ON) begin
            lit_anode[digit_q] = 1'b1;
            lit_seg            = shadow_q[digit_q];
        end

        if (!enable) begin
            // Abort from any state; also suppresses a coincident frame end.
            state_d   = ST_IDLE;
            digit_d   = '0;
            tmr_clear = 1'b1;
            lit_anode = '0;
            lit_seg   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    digit_d     = '0;
                    shadow_d    = seg_in;
                    start_digit = 1'b1;
                end
                ST_BLANK: begin
                    if (tmr_tc) begin
                        state_d  = ST_ON;
                        tmr_load = 1'b1;
                        tmr_val  = DIGIT_CYCLES;
                    end
                end
                ST_ON: begin
                    if (tmr_tc) begin
                        if (digit_q == DIGIT_W'(NUM_DIGITS - 1)) begin
                            frame_done_d = 1'b1;
                            digit_d      = '0;
                            shadow_d     = seg_in;
                        end else begin
                            digit_d = digit_q + DIGIT_W'(1);
                        end
                        start_digit = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A new digit begins with its blank phase, or straight in ON
            // when no blanking is configured.
            if (start_digit) begin
                tmr_load = 1'b1;
                if (HAS_BLANK) begin
                    state_d = ST_BLANK;
                    tmr_val = BLANK_LOAD;
                end else begin
                    state_d = ST_ON;
                    tmr_val = DIGIT_CYCLES;
                end
            end
        end

        anode_d   = lit_anode ^ ANODE_OFF;
        cathode_d = lit_seg ^ SEG_OFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            digit_q      <= '0;
            shadow_q     <= '0;
            anode_q      <= ANODE_OFF;
            cathode_q    <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan.sv
// ----------------------------------------------------------------------------
// tb_display_scan
// Two scanners share all inputs: u_dut0 (DIGIT_CYCLES=4, BLANK_CYCLES=2) and
// u_dut1 (DIGIT_CYCLES=4, BLANK_CYCLES=0), both active-low. A behavioural
// model derives the expected outputs from the number of clocks since scanning
// started; directed scenarios are pinned with literal values, then a random
// phase exercises enable, reset and mid-frame pattern changes.
// ----------------------------------------------------------------------------
module tb_display_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] segment0 = 8'h00;
    logic [7:0] segment1 = 8'h00;
    logic [7:0] segment2 = 8'h00;
    logic [7:0] segment3 = 8'h00;
    logic [3:0] anode0, anode1;
    logic [7:0] cathode0, cathode1;
    logic       fd0, fd1;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    display_scan #(
        .DIGIT_CYCLES(16'd4), .BLANK_CYCLES(8'd2),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .segment0(segment0), .segment1(segment1),
        .segment2(segment2), .segment3(segment3),
        .anode(anode0), .cathode(cathode0), .frame_done(fd0)
    );

    display_scan #(
        .DIGIT_CYCLES(16'd4), .BLANK_CYCLES(8'd0),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .segment0(segment0), .segment1(segment1),
        .segment2(segment2), .segment3(segment3),
        .anode(anode1), .cathode(cathode1), .frame_done(fd1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int j);
        case (j)
            0: return segment0;
            1: return segment1;
            2: return segment2;
            default: return segment3;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: k = clocks since enable was first sampled high.
    // Output after edge k (k>=1) is position (k-1) mod frame within the
    // frame; each digit slot is blank clocks then on clocks. Patterns are
    // captured at k=0 and at every k that is a multiple of the frame.
    // ------------------------------------------------------------------
    int         m_blank [2] = '{2, 0};
    int         m_on    [2] = '{4, 4};
    logic       m_act   [2];
    int         m_k     [2];
    logic [7:0] m_sh    [2][4];
    logic [3:0] e_an    [2] = '{4'hF, 4'hF};
    logic [7:0] e_ca    [2] = '{8'hFF, 8'hFF};
    logic       e_fd    [2] = '{1'b0, 1'b0};
    int         per, frame, pos, dig;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                for (int j = 0; j < 4; j++) m_sh[i][j] = 8'h00;
                e_an[i] = 4'hF;
                e_ca[i] = 8'hFF;
                e_fd[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_an[i] = 4'hF;
                e_ca[i] = 8'hFF;
                e_fd[i] = 1'b0;
                if (!enable) begin
                    m_act[i] = 1'b0;
                    m_k[i]   = 0;
                end else if (!m_act[i]) begin
                    m_act[i] = 1'b1;
                    m_k[i]   = 0;
                    for (int j = 0; j < 4; j++) m_sh[i][j] = seg_of(j);
                end else begin
                    m_k[i] = m_k[i] + 1;
                    per   = m_blank[i] + m_on[i];
                    frame = 4 * per;
                    pos   = (m_k[i] - 1) % frame;
                    dig   = pos / per;
                    if ((pos % per) >= m_blank[i]) begin
                        e_an[i] = 4'hF ^ (4'h1 << dig);
                        e_ca[i] = ~m_sh[i][dig];
                    end
                    e_fd[i] = (pos == frame - 1);
                    if ((m_k[i] % frame) == 0)
                        for (int j = 0; j < 4; j++) m_sh[i][j] = seg_of(j);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_anode0",   {4'h0, anode0}, {4'h0, e_an[0]});
            chk("model_cathode0", cathode0,       e_ca[0]);
            chk("model_fdone0",   {7'h0, fd0},    {7'h0, e_fd[0]});
            chk("model_anode1",   {4'h0, anode1}, {4'h0, e_an[1]});
            chk("model_cathode1", cathode1,       e_ca[1]);
            chk("model_fdone1",   {7'h0, fd1},    {7'h0, e_fd[1]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_anode0",   {4'h0, anode0}, 8'h0F);
        chk("rst_cathode0", cathode0,       8'hFF);
        chk("rst_fdone0",   {7'h0, fd0},    8'h00);
        chk("rst_anode1",   {4'h0, anode1}, 8'h0F);
        @(negedge clk) reset = 1'b1;

        // Basic scan, mid-frame pattern change, enable drop during digit 2
        @(negedge clk);
        segment0 = 8'h3F; segment1 = 8'h06; segment2 = 8'h5B; segment3 = 8'h4F;
        enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 63; k++) begin
            step();
            if (k == 2)  begin chk("blank_anode0", {4'h0, anode0}, 8'h0F); chk("blank_cath0", cathode0, 8'hFF); end
            if (k == 3)  begin chk("d0_anode0", {4'h0, anode0}, 8'h0E); chk("d0_cath0", cathode0, 8'hC0);
                               chk("d0_anode1", {4'h0, anode1}, 8'h0E); chk("d0_cath1", cathode1, 8'hC0); end
            if (k == 5)  begin chk("d1_anode1", {4'h0, anode1}, 8'h0D); chk("d1_cath1", cathode1, 8'hF9); end
            if (k == 6)  chk("d0_last_anode0", {4'h0, anode0}, 8'h0E);
            if (k == 7)  chk("d1_blank_anode0", {4'h0, anode0}, 8'h0F);
            if (k == 9)  begin chk("d1_anode0", {4'h0, anode0}, 8'h0D); chk("d1_cath0", cathode0, 8'hF9); end
            if (k == 15) begin chk("d2_anode0", {4'h0, anode0}, 8'h0B); chk("d2_cath0", cathode0, 8'hA4); end
            if (k == 16) begin chk("fdone1", {7'h0, fd1}, 8'h01); chk("d3_cath1", cathode1, 8'hB0); end
            if (k == 17) chk("wrap_anode1", {4'h0, anode1}, 8'h0E);
            if (k == 21) begin chk("d3_anode0", {4'h0, anode0}, 8'h07); chk("d3_cath0", cathode0, 8'hB0);
                               chk("new_d1_cath1", cathode1, 8'h80); end
            if (k == 23) chk("pre_fdone0", {7'h0, fd0}, 8'h00);
            if (k == 24) begin chk("fdone0", {7'h0, fd0}, 8'h01); chk("fd_anode0", {4'h0, anode0}, 8'h07); end
            if (k == 25) begin chk("post_fdone0", {7'h0, fd0}, 8'h00); chk("f1_blank0", {4'h0, anode0}, 8'h0F); end
            if (k == 33) begin chk("f1_d1_anode0", {4'h0, anode0}, 8'h0D); chk("f1_d1_cath0", cathode0, 8'h80); end
            if (k == 14) segment1 = 8'h7F;
            if (k == 63) begin chk("f2_d2_anode0", {4'h0, anode0}, 8'h0B); enable = 1'b0; end
        end
        step();
        chk("drop_anode0", {4'h0, anode0}, 8'h0F);
        chk("drop_cath0",  cathode0,       8'hFF);
        chk("drop_fdone0", {7'h0, fd0},    8'h00);
        repeat (3) step();

        // Re-enable, then drop enable exactly on the frame-end edge
        enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 2) chk("re_blank0", {4'h0, anode0}, 8'h0F);
            if (k == 3) chk("re_d0_anode0", {4'h0, anode0}, 8'h0E);
            if (k == 23) enable = 1'b0;
            if (k == 24) begin chk("fe_fdone0", {7'h0, fd0}, 8'h00); chk("fe_anode0", {4'h0, anode0}, 8'h0F);
                               chk("fe_cath0", cathode0, 8'hFF); end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fe_idle_fdone0", {7'h0, fd0}, 8'h00);
        end

        // Asynchronous reset in the middle of digit 3 drive
        enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 22; k++) step();
        chk("pre_rst_anode0", {4'h0, anode0}, 8'h07);
        #2 reset = 1'b0;
        #1;
        chk("arst_anode0",   {4'h0, anode0}, 8'h0F);
        chk("arst_cathode0", cathode0,       8'hFF);
        chk("arst_fdone0",   {7'h0, fd0},    8'h00);
        repeat (3) begin
            step();
            chk("arst_hold_fdone0", {7'h0, fd0}, 8'h00);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 3) begin chk("rst_restart_anode0", {4'h0, anode0}, 8'h0E);
                              chk("rst_restart_cath0", cathode0, 8'hC0); end
        end

        // Random phase: pattern churn, enable toggles, occasional reset pulse
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: segment0 = 8'($urandom);
                    1: segment1 = 8'($urandom);
                    2: segment2 = 8'($urandom);
                    default: segment3 = 8'($urandom);
                endcase
            end
            if (enable && $urandom_range(0, 149) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 5) == 0) enable = 1'b1;
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b0;
                @(posedge clk);
                #2 reset = 1'b1;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
